obstacle_spawner: RTL and testbench

Consumes the free-running 30-bit LFSR output and turns it, on request, into one bounded spawn descriptor (horizontal position plus fall speed) for the game logic. Sits directly downstream of the LFSR and upstream of the object/playfield controller. It uses a request / valid-ack handshake, a sequential modulo reduction, and a post-spawn cooldown with a one-deep pending-request latch.

---
 rtl/obstacle_spawner_pkg.sv | 17 +
 rtl/obstacle_spawner_if.sv | 24 ++
 rtl/obstacle_spawner_mod_reducer.sv | 38 +++
 rtl/obstacle_spawner.sv | 132 +++++++++++++
 tb/tb_obstacle_spawner.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/obstacle_spawner_pkg.sv
// Shared types and widths for the obstacle spawner: FSM state encoding and
// the bit widths of the LFSR input and the spawn descriptor fields.
package obstacle_spawner_pkg;

  localparam int RAND_W = 30;
  localparam int X_W    = 10;
  localparam int SPD_W  = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_COOL   = 2'd3
  } state_e;

endpackage

// File: rtl/obstacle_spawner_if.sv
// Request/descriptor bundle between the game logic (master) and the spawner
// (slave); the LFSR state rides along because it is only sampled at start.
interface obstacle_spawner_if;
  import obstacle_spawner_pkg::*;

  logic [RAND_W-1:0] rand_bits;
  logic              req;
  logic              ack;
  logic              valid;
  logic [X_W-1:0]    x_pos;
  logic [SPD_W-1:0]  speed;
  logic              busy;

  modport master (
    output rand_bits, req, ack,
    input  valid, x_pos, speed, busy
  );

  modport slave (
    input  rand_bits, req, ack,
    output valid, x_pos, speed, busy
  );

endinterface

// File: rtl/obstacle_spawner_mod_reducer.sv
// Sequential modulo datapath: loads a 10-bit value and subtracts X_RANGE one
// step per cycle until the remainder drops below X_RANGE.
module mod_reducer
  import obstacle_spawner_pkg::*;
#(
  parameter int X_RANGE = 600
) (
  input  logic           clk,
  input  logic           load,
  input  logic [X_W-1:0] load_val,
  input  logic           step,
  output logic [X_W-1:0] work,
  output logic           done
);

  localparam logic [X_W-1:0] RANGE_C = X_W'(X_RANGE);

  logic [X_W-1:0] work_q;
  logic [X_W-1:0] work_d;

  // The compare guards the subtraction, so work never wraps below zero.
  always_comb begin
    work_d = work_q;
    if (load) begin
      work_d = load_val;
    end else if (step && (work_q >= RANGE_C)) begin
      work_d = work_q - RANGE_C;
    end
  end

  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  assign work = work_q;
  assign done = (work_q < RANGE_C);

endmodule

// File: rtl/obstacle_spawner.sv
// Turns the free-running LFSR state into one bounded spawn descriptor per
// request, with a post-ack cooldown and a one-deep pending-request latch.
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int X_MIN   = 16,
  parameter int X_RANGE = 600,
  parameter int GAP     = 8
) (
  input  logic               clk,
  input  logic               rst,
  obstacle_spawner_if.slave  bus
);

  localparam logic [X_W-1:0]   X_MIN_C = X_W'(X_MIN);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP);

  // A zero speed would freeze the object, so it is lifted to the slowest one.
  function automatic logic [SPD_W-1:0] sat_speed(input logic [SPD_W-1:0] s);
    return (s == '0) ? SPD_W'(1) : s;
  endfunction

  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [X_W-1:0]     x_pos_q, x_pos_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic [SPD_W-1:0]   spd_q, spd_d;

  logic               red_load;
  logic               red_step;
  logic [X_W-1:0]     red_work;
  logic               red_done;
  logic               unused_rand;

  assign unused_rand = ^bus.rand_bits[RAND_W-1:X_W+SPD_W];

  mod_reducer #(
    .X_RANGE (X_RANGE)
  ) u_reducer (
    .clk      (clk),
    .load     (red_load),
    .load_val (bus.rand_bits[X_W-1:0]),
    .step     (red_step),
    .work     (red_work),
    .done     (red_done)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    x_pos_d   = x_pos_q;
    speed_d   = speed_q;
    spd_d     = spd_q;
    red_load  = 1'b0;
    red_step  = 1'b0;

    if ((state_q != ST_IDLE) && bus.req) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req || pending_q) begin
          red_load  = 1'b1;
          spd_d     = bus.rand_bits[X_W+SPD_W-1:X_W];
          pending_d = 1'b0;
          state_d   = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (!red_done) begin
          red_step = 1'b1;
        end else begin
          x_pos_d = red_work + X_MIN_C;
          speed_d = sat_speed(spd_q);
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.ack) begin
          valid_d = 1'b0;
          if (GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = GAP_C;
            state_d = ST_COOL;
          end
        end
      end
      ST_COOL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      x_pos_q   <= '0;
      speed_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      x_pos_q   <= x_pos_d;
      speed_q   <= speed_d;
    end
  end

  always_ff @(posedge clk) begin
    spd_q <= spd_d;
  end

  assign bus.valid = valid_q;
  assign bus.x_pos = x_pos_q;
  assign bus.speed = speed_q;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench: one spawner with X_RANGE=600/GAP=8 and one with
// X_RANGE=100/GAP=0, driven and sampled on the falling clock edge.
module tb_obstacle_spawner;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  obstacle_spawner_if if_a ();
  obstacle_spawner_if if_b ();

  obstacle_spawner #(.X_MIN(16), .X_RANGE(600), .GAP(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  obstacle_spawner #(.X_MIN(16), .X_RANGE(100), .GAP(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input logic v, input int x, input int s, input logic b);
    chk({tag, ".valid"}, 32'(if_a.valid), 32'(v));
    chk({tag, ".x_pos"}, 32'(if_a.x_pos), 32'(x));
    chk({tag, ".speed"}, 32'(if_a.speed), 32'(s));
    chk({tag, ".busy"},  32'(if_a.busy),  32'(b));
  endtask

  task automatic chk_b(input string tag, input logic v, input int x, input int s, input logic b);
    chk({tag, ".valid"}, 32'(if_b.valid), 32'(v));
    chk({tag, ".x_pos"}, 32'(if_b.x_pos), 32'(x));
    chk({tag, ".speed"}, 32'(if_b.speed), 32'(s));
    chk({tag, ".busy"},  32'(if_b.busy),  32'(b));
  endtask

  initial begin
    rst = 1'b1;
    if_a.rand_bits = '0; if_a.req = 1'b0; if_a.ack = 1'b0;
    if_b.rand_bits = '0; if_b.req = 1'b0; if_b.ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_a("rst_a", 1'b0, 0, 0, 1'b0);
    chk_b("rst_b", 1'b0, 0, 0, 1'b0);
    chk("rst_a.pending", 32'(dut_a.pending_q), 32'd0);

    // rand=100, speed bits 0: no subtraction, speed lifted to 1
    if_a.rand_bits = 30'({3'd0, 10'd100});
    if_a.req = 1'b1;
    tick();
    if_a.req = 1'b0;
    chk_a("t1_n", 1'b0, 0, 0, 1'b1);
    tick();
    chk_a("t1_n1", 1'b1, 116, 1, 1'b1);
    if_a.ack = 1'b1;
    tick();
    if_a.ack = 1'b0;
    chk_a("t1_ack", 1'b0, 116, 1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t1_cool.busy", 32'(if_a.busy), (k < 8) ? 32'd1 : 32'd0);
    end

    // rand=700: one subtraction; rand changes after the start must not matter
    if_a.rand_bits = 30'({3'd5, 10'd700});
    if_a.req = 1'b1;
    tick();
    if_a.req = 1'b0;
    if_a.rand_bits = 30'h3FFF_FFFF;
    tick();
    chk_a("t2_n1", 1'b0, 116, 1, 1'b1);
    tick();
    chk_a("t2_n2", 1'b1, 116, 5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_a("t2_hold", 1'b1, 116, 5, 1'b1);
    end

    // ack and req together: pending set, second start at M+9
    if_a.rand_bits = 30'({3'd7, 10'd200});
    if_a.ack = 1'b1;
    if_a.req = 1'b1;
    tick();
    if_a.ack = 1'b0;
    if_a.req = 1'b0;
    chk_a("t3_m", 1'b0, 116, 5, 1'b1);
    chk("t3_m.pending", 32'(dut_a.pending_q), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t3_cool.busy", 32'(if_a.busy), (k < 8) ? 32'd1 : 32'd0);
      if (k == 2) if_a.req = 1'b1;
      if (k == 3) if_a.req = 1'b0;
    end
    chk("t3_m8.valid", 32'(if_a.valid), 32'd0);
    tick();
    chk_a("t3_m9", 1'b0, 116, 5, 1'b1);
    chk("t3_m9.pending", 32'(dut_a.pending_q), 32'd0);
    tick();
    chk_a("t3_m10", 1'b1, 216, 7, 1'b1);
    if_a.ack = 1'b1;
    tick();
    if_a.ack = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("t3_drop.valid", 32'(if_a.valid), 32'd0);
    end
    chk("t3_drop.busy", 32'(if_a.busy), 32'd0);

    // X_RANGE=100, rand=1023: ten subtractions, valid after N+11
    if_b.rand_bits = 30'({3'd0, 10'd1023});
    if_b.req = 1'b1;
    tick();
    if_b.req = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      chk("t4_wait.valid", 32'(if_b.valid), 32'd0);
      tick();
    end
    chk_b("t4_n11", 1'b1, 39, 1, 1'b1);

    // GAP=0: ack with req -> next start at M+1; ack while valid=0 ignored
    if_b.rand_bits = 30'({3'd3, 10'd5});
    if_b.ack = 1'b1;
    if_b.req = 1'b1;
    tick();
    if_b.req = 1'b0;
    chk_b("t5_m", 1'b0, 39, 1, 1'b0);
    chk("t5_m.pending", 32'(dut_b.pending_q), 32'd1);
    tick();
    chk_b("t5_m1", 1'b0, 39, 1, 1'b1);
    tick();
    if_b.ack = 1'b0;
    chk_b("t5_m2", 1'b1, 21, 3, 1'b1);
    if_b.rand_bits = 30'({3'd0, 10'd250});
    if_b.req = 1'b1;
    tick();
    if_b.req = 1'b0;
    chk_b("t5_m3", 1'b1, 21, 3, 1'b1);
    chk("t5_m3.pending", 32'(dut_b.pending_q), 32'd1);
    if_b.ack = 1'b1;
    tick();
    if_b.ack = 1'b0;
    chk_b("t5_m4", 1'b0, 21, 3, 1'b0);
    tick();
    chk("t5_m5.busy", 32'(if_b.busy), 32'd1);
    tick();
    chk("t5_m6.valid", 32'(if_b.valid), 32'd0);
    tick();
    chk("t5_m7.valid", 32'(if_b.valid), 32'd0);
    tick();
    chk_b("t5_m8", 1'b1, 66, 1, 1'b1);
    if_b.ack = 1'b1;
    tick();
    if_b.ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_b("t5_idle", 1'b0, 66, 1, 1'b0);
    end

    // Reset while holding a descriptor
    if_a.rand_bits = 30'({3'd4, 10'd100});
    if_a.req = 1'b1;
    tick();
    if_a.req = 1'b1;
    tick();
    if_a.req = 1'b0;
    chk_a("t6_hold", 1'b1, 116, 4, 1'b1);
    chk("t6_hold.pending", 32'(dut_a.pending_q), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_a("t6_rst", 1'b0, 0, 0, 1'b0);
    chk("t6_rst.pending", 32'(dut_a.pending_q), 32'd0);
    tick();
    chk_a("t6_after", 1'b0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
